// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, forwarding sources and EX-side outputs of the
// ID/EX stage. The stage uses the slave view; the upstream/driver uses master.
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  // decode stage
  logic               in_valid;
  logic [XLEN-1:0]    in_pc;
  logic [6:0]         in_opcode;
  logic [2:0]         in_funct3;
  logic               in_funct7b5;
  logic [REGADDR-1:0] in_rs1;
  logic [REGADDR-1:0] in_rs2;
  logic [REGADDR-1:0] in_rd;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  // forwarding sources
  logic [REGADDR-1:0] exm_rd;
  logic               exm_regwrite;
  logic [XLEN-1:0]    exm_data;
  logic [REGADDR-1:0] wb_rd;
  logic               wb_regwrite;
  logic [XLEN-1:0]    wb_data;
  logic               flush;
  // EX stage side
  logic               stall_req;
  logic               out_valid;
  logic [XLEN-1:0]    alu_x;
  logic [XLEN-1:0]    alu_y;
  logic [3:0]         alu_fn;
  logic [XLEN-1:0]    store_data;
  logic [XLEN-1:0]    out_pc;
  logic [REGADDR-1:0] out_rd;
  logic               out_regwrite;
  logic               out_memread;
  logic               out_memwrite;
  logic               out_branch;
  logic               out_illegal;

  modport master (
    output in_valid, in_pc, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
           in_rs1_data, in_rs2_data, in_imm, exm_rd, exm_regwrite, exm_data,
           wb_rd, wb_regwrite, wb_data, flush,
    input  stall_req, out_valid, alu_x, alu_y, alu_fn, store_data, out_pc, out_rd,
           out_regwrite, out_memread, out_memwrite, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
           in_rs1_data, in_rs2_data, in_imm, exm_rd, exm_regwrite, exm_data,
           wb_rd, wb_regwrite, wb_data, flush,
    output stall_req, out_valid, alu_x, alu_y, alu_fn, store_data, out_pc, out_rd,
           out_regwrite, out_memread, out_memwrite, out_branch, out_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU function, resolves operand
// forwarding, detects load-use hazards and registers everything for EX.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  logic [3:0]         fn_next;
  logic               regwrite_next;
  logic               memread_next;
  logic               memwrite_next;
  logic               branch_next;
  logic               illegal_next;
  logic               uses_rs2;
  logic               use_imm;

  logic [REGADDR-1:0] rs_idx   [2];
  logic [XLEN-1:0]    rf_data  [2];
  logic [XLEN-1:0]    fwd_data [2];

  logic [XLEN-1:0]    x_next;
  logic [XLEN-1:0]    y_next;
  logic               hazard;

  logic               valid_reg;
  logic [XLEN-1:0]    x_reg;
  logic [XLEN-1:0]    y_reg;
  logic [3:0]         fn_reg;
  logic [XLEN-1:0]    store_reg;
  logic [XLEN-1:0]    pc_reg;
  logic [REGADDR-1:0] rd_reg;
  logic               regwrite_reg;
  logic               memread_reg;
  logic               memwrite_reg;
  logic               branch_reg;
  logic               illegal_reg;

  // Decode opcode/funct3/funct7[5] into ALU code, controls and operand usage
  always_comb begin
    fn_next       = ALU_ADD;
    regwrite_next = 1'b0;
    memread_next  = 1'b0;
    memwrite_next = 1'b0;
    branch_next   = 1'b0;
    illegal_next  = 1'b0;
    uses_rs2      = 1'b0;
    use_imm       = 1'b0;
    case (bus.in_opcode)
      OP_R, OP_I: begin
        regwrite_next = 1'b1;
        uses_rs2      = (bus.in_opcode == OP_R);
        use_imm       = (bus.in_opcode == OP_I);
        case (bus.in_funct3)
          3'b000:  fn_next = (bus.in_opcode == OP_R && bus.in_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  fn_next = ALU_AND;
          3'b110:  fn_next = ALU_OR;
          3'b100:  fn_next = ALU_XOR;
          3'b001:  fn_next = ALU_SLL;
          3'b101: begin
            // arithmetic right shift is not supported by this ALU
            if (bus.in_funct7b5) illegal_next = 1'b1;
            else                 fn_next = ALU_SRL;
          end
          default: illegal_next = 1'b1;
        endcase
      end
      OP_LOAD: begin
        use_imm       = 1'b1;
        memread_next  = 1'b1;
        regwrite_next = 1'b1;
      end
      OP_STORE: begin
        use_imm       = 1'b1;
        uses_rs2      = 1'b1;
        memwrite_next = 1'b1;
      end
      OP_BRANCH: begin
        fn_next     = ALU_SUB;
        uses_rs2    = 1'b1;
        branch_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    // an illegal instruction must not write anything or redirect control flow
    if (illegal_next) begin
      regwrite_next = 1'b0;
      memread_next  = 1'b0;
      memwrite_next = 1'b0;
      branch_next   = 1'b0;
    end
  end

  assign rs_idx[0]  = bus.in_rs1;
  assign rs_idx[1]  = bus.in_rs2;
  assign rf_data[0] = bus.in_rs1_data;
  assign rf_data[1] = bus.in_rs2_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Per-operand forwarding: EX/MEM wins over MEM/WB; x0 is never forwarded
      always_comb begin
        fwd_data[gi] = rf_data[gi];
        if (bus.exm_regwrite && bus.exm_rd != '0 && bus.exm_rd == rs_idx[gi])
          fwd_data[gi] = bus.exm_data;
        else if (bus.wb_regwrite && bus.wb_rd != '0 && bus.wb_rd == rs_idx[gi])
          fwd_data[gi] = bus.wb_data;
      end
    end
  endgenerate

  assign x_next = fwd_data[0];
  assign y_next = use_imm ? bus.in_imm : fwd_data[1];

  // A load in EX cannot forward in time; hold decode when its rd is consumed
  assign hazard = bus.in_valid && valid_reg && memread_reg && (rd_reg != '0) &&
                  ((rd_reg == bus.in_rs1) || (uses_rs2 && rd_reg == bus.in_rs2));
  assign bus.stall_req = hazard && !bus.flush;

  // Pipeline register: flush, hazard and idle decode all insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      fn_reg       <= '0;
      store_reg    <= '0;
      pc_reg       <= '0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      branch_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
    end else if (bus.flush || hazard || !bus.in_valid) begin
      valid_reg    <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      fn_reg       <= '0;
      store_reg    <= '0;
      pc_reg       <= '0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      branch_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      valid_reg    <= 1'b1;
      x_reg        <= x_next;
      y_reg        <= y_next;
      fn_reg       <= fn_next;
      store_reg    <= fwd_data[1];
      pc_reg       <= bus.in_pc;
      rd_reg       <= bus.in_rd;
      regwrite_reg <= regwrite_next;
      memread_reg  <= memread_next;
      memwrite_reg <= memwrite_next;
      branch_reg   <= branch_next;
      illegal_reg  <= illegal_next;
    end
  end

  assign bus.out_valid    = valid_reg;
  assign bus.alu_x        = x_reg;
  assign bus.alu_y        = y_reg;
  assign bus.alu_fn       = fn_reg;
  assign bus.store_data   = store_reg;
  assign bus.out_pc       = pc_reg;
  assign bus.out_rd       = rd_reg;
  assign bus.out_regwrite = regwrite_reg;
  assign bus.out_memread  = memread_reg;
  assign bus.out_memwrite = memwrite_reg;
  assign bus.out_branch   = branch_reg;
  assign bus.out_illegal  = illegal_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use stall, flush, reset.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  id_ex_stage_if #(.XLEN(32), .REGADDR(5)) bus ();

  id_ex_stage #(.XLEN(32), .REGADDR(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.in_pc       = 32'h0000_1000 + {27'd0, rd};
    bus.in_opcode   = op;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7b5;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = rd;
    bus.in_rs1_data = d1;
    bus.in_rs2_data = d2;
    bus.in_imm      = imm;
  endtask

  task automatic no_fwd();
    bus.exm_rd = '0; bus.exm_regwrite = 1'b0; bus.exm_data = '0;
    bus.wb_rd  = '0; bus.wb_regwrite  = 1'b0; bus.wb_data  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    instr(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    bus.in_valid = 1'b0;
    no_fwd();
    #12;
    chk("rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("rst_alu_x",    bus.alu_x, 32'd0);
    chk("rst_alu_fn",   {28'd0, bus.alu_fn}, 32'd0);
    chk("rst_stall",    {31'd0, bus.stall_req}, 32'd0);
    chk("rst_regwrite", {31'd0, bus.out_regwrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB, no forwarding
    tick();
    instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0);
    tick();
    chk("sub_x",        bus.alu_x, 32'd9);
    chk("sub_y",        bus.alu_y, 32'd4);
    chk("sub_fn",       {28'd0, bus.alu_fn}, 32'h6);
    chk("sub_regwrite", {31'd0, bus.out_regwrite}, 32'd1);
    chk("sub_valid",    {31'd0, bus.out_valid}, 32'd1);
    chk("sub_rd",       {27'd0, bus.out_rd}, 32'd3);
    chk("sub_pc",       bus.out_pc, 32'h0000_1003);

    // forwarding priority: EX/MEM over MEM/WB
    instr(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd5, 5'd4, 32'h99, 32'h77, 32'd0);
    bus.exm_rd = 5'd5; bus.exm_regwrite = 1'b1; bus.exm_data = 32'h11;
    bus.wb_rd  = 5'd5; bus.wb_regwrite  = 1'b1; bus.wb_data  = 32'h22;
    tick();
    chk("fwd_exm_x",    bus.alu_x, 32'h11);
    chk("fwd_exm_y",    bus.alu_y, 32'h11);
    chk("fwd_exm_st",   bus.store_data, 32'h11);
    chk("fwd_add_fn",   {28'd0, bus.alu_fn}, 32'h2);
    bus.exm_regwrite = 1'b0;
    tick();
    chk("fwd_wb_x",     bus.alu_x, 32'h22);
    bus.in_rs1 = 5'd0; bus.exm_rd = 5'd0; bus.wb_rd = 5'd0;
    bus.exm_regwrite = 1'b1;
    tick();
    chk("fwd_x0_x",     bus.alu_x, 32'h99);
    no_fwd();

    // load-use hazard on rs2
    instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd8);
    tick();
    chk("ld_memread",   {31'd0, bus.out_memread}, 32'd1);
    chk("ld_y_imm",     bus.alu_y, 32'd8);
    chk("ld_x",         bus.alu_x, 32'h100);
    instr(7'b0110011, 3'b000, 1'b0, 5'd2, 5'd7, 5'd8, 32'h5, 32'h6, 32'd0);
    #1;
    chk("lu_stall",     {31'd0, bus.stall_req}, 32'd1);
    tick();
    chk("lu_bubble",    {31'd0, bus.out_valid}, 32'd0);
    chk("lu_bubble_x",  bus.alu_x, 32'd0);
    chk("lu_stall_off", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("lu_capture",   {31'd0, bus.out_valid}, 32'd1);
    chk("lu_cap_y",     bus.alu_y, 32'h6);

    // I-type reading no rs2: rs2 field matching a load rd must not stall
    instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd8);
    tick();
    instr(7'b0010011, 3'b000, 1'b0, 5'd2, 5'd7, 5'd9, 32'h5, 32'h6, 32'd3);
    #1;
    chk("iimm_nostall", {31'd0, bus.stall_req}, 32'd0);

    // flush during hazard
    instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd8);
    tick();
    instr(7'b0110011, 3'b000, 1'b0, 5'd2, 5'd7, 5'd8, 32'h5, 32'h6, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall",     {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("fl_valid",     {31'd0, bus.out_valid}, 32'd0);
    chk("fl_memread",   {31'd0, bus.out_memread}, 32'd0);
    bus.flush = 1'b0;

    // SRAI is illegal
    instr(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd3, 5'd4, 32'h5, 32'h6, 32'd3);
    tick();
    chk("srai_illegal", {31'd0, bus.out_illegal}, 32'd1);
    chk("srai_regwr",   {31'd0, bus.out_regwrite}, 32'd0);
    chk("srai_valid",   {31'd0, bus.out_valid}, 32'd1);

    // ADDI with imm = -1
    instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd3, 5'd4, 32'h5, 32'h6, 32'hFFFF_FFFF);
    tick();
    chk("addi_y",       bus.alu_y, 32'hFFFF_FFFF);
    chk("addi_fn",      {28'd0, bus.alu_fn}, 32'h2);
    chk("addi_illegal", {31'd0, bus.out_illegal}, 32'd0);

    // BRANCH and idle decode
    instr(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 32'd16);
    tick();
    chk("br_fn",        {28'd0, bus.alu_fn}, 32'h6);
    chk("br_branch",    {31'd0, bus.out_branch}, 32'd1);
    chk("br_y",         bus.alu_y, 32'h6);
    bus.in_valid = 1'b0;
    tick();
    chk("idle_valid",   {31'd0, bus.out_valid}, 32'd0);

    // asynchronous reset between edges while a hazard is pending
    instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd8);
    tick();
    instr(7'b0110011, 3'b000, 1'b0, 5'd7, 5'd2, 5'd8, 32'h5, 32'h6, 32'd0);
    #1;
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst_stall", {31'd0, bus.stall_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   {31'd0, bus.out_valid}, 32'd0);
    chk("arst_y",       bus.alu_y, 32'd0);
    chk("arst_memread", {31'd0, bus.out_memread}, 32'd0);
    chk("arst_stall",   {31'd0, bus.stall_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
